// File: rtl/cla_seq_adder_ctrl.sv
// Sequencer that computes a WIDTH-bit add/subtract on one shared 4-bit carry-lookahead
// slice, one nibble per clock, LSB first; it derives the group carry-out itself.
module cla_seq_adder_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             sub_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o,
    output logic             ovf_o,
    output logic [3:0]       slice_g_o,
    output logic [3:0]       slice_p_o,
    output logic             slice_cin_o,
    input  logic [3:0]       slice_s_i
);

    localparam int unsigned NIB  = WIDTH / 4;
    localparam int unsigned IdxW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIB - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q;
    logic [IdxW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              ovf_q;

    logic [3:0]        nib_a;
    logic [3:0]        nib_b;
    logic [3:0]        g;
    logic [3:0]        p;
    logic              c3;
    logic              c4;
    logic              run;

    always_comb begin
        run   = (state_q == StRun);
        nib_a = a_q[{idx_q, 2'b00} +: 4];
        nib_b = b_q[{idx_q, 2'b00} +: 4];
        g     = nib_a & nib_b;
        p     = nib_a ^ nib_b;
        // Lookahead terms mirror the slice; c3 is needed only for overflow detection.
        c3    = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & carry_q);
        c4    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & carry_q);
    end

    always_comb begin
        ready_o     = (state_q == StIdle);
        busy_o      = (state_q == StRun) || (state_q == StDone);
        done_o      = (state_q == StDone);
        sum_o       = sum_q;
        cout_o      = cout_q;
        ovf_o       = ovf_q;
        slice_g_o   = run ? g : 4'b0000;
        slice_p_o   = run ? p : 4'b0000;
        slice_cin_o = run & carry_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start_i) begin
                        // Subtraction is a + ~b + 1; the +1 enters as the initial carry.
                        a_q     <= a_i;
                        b_q     <= sub_i ? ~b_i : b_i;
                        carry_q <= sub_i;
                        idx_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= slice_s_i;
                    carry_q <= c4;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LastIdx) begin
                        cout_q  <= c4;
                        ovf_q   <= c3 ^ c4;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
